// File: rtl/fft_bfly2_pipe.sv
// fft_bfly2_pipe -- pipelined radix-2 DIT butterfly.
//
// Each accepted beat produces X1 = A + B*W and X2 = A - B*W.
// The beat can optionally use conj(W), which gives the inverse transform.
// The beat can also be scaled by an extra /2.
// Latency is three register stages, and the block accepts up to one beat per clock.
//
// Ports
//   clk, rst           clock (rising edge); asynchronous active-high reset
//   val_i / rdy_o      input handshake; rdy_o = ~val_o | rdy_i (combinational)
//   dat1_i, dat2_i     A and B, each {re, im}, DATA_INP_WD bits per part
//   wn_i               twiddle W {re, im}, WN_WD bits per part, FRA_WD fraction bits
//   inv_i              per beat: use conj(W)
//   scl_i              per beat: extra right shift by one
//   val_o / rdy_i      output handshake; the whole pipeline stalls when val_o & ~rdy_i
//   dat1_o, dat2_o     X1 and X2, each {re, im}, DATA_OUT_WD bits per part
//   ovf_o, ovf_clr_i   sticky range-overflow flag and its synchronous clear
module fft_bfly2_pipe #(
  parameter int DATA_INP_WD = 16,
  parameter int DATA_OUT_WD = 17,
  parameter int WN_WD       = 16,
  parameter int FRA_WD      = 14,
  parameter int RND_MODE    = 1,
  parameter int SAT_EN      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       val_i,
  output logic                       rdy_o,
  input  logic [2*DATA_INP_WD-1:0]   dat1_i,
  input  logic [2*DATA_INP_WD-1:0]   dat2_i,
  input  logic [2*WN_WD-1:0]         wn_i,
  input  logic                       inv_i,
  input  logic                       scl_i,
  output logic                       val_o,
  input  logic                       rdy_i,
  output logic [2*DATA_OUT_WD-1:0]   dat1_o,
  output logic [2*DATA_OUT_WD-1:0]   dat2_o,
  output logic                       ovf_o,
  input  logic                       ovf_clr_i
);

  localparam int PW = DATA_INP_WD + WN_WD + 2;         // complex product width
  localparam int AW = DATA_INP_WD + FRA_WD;            // A aligned to the product scale
  localparam int SW = ((AW > PW) ? AW : PW) + 2;       // guard bit + rounding headroom
  localparam int DO = DATA_OUT_WD;

  // Round-half-up adds half an LSB of the final result, then shifts arithmetically.
  function automatic logic signed [SW-1:0] scale(input logic signed [SW-1:0] s,
                                                 input logic sc);
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] t;
    rnd = '0;
    if (RND_MODE != 0) begin
      if (sc) rnd[FRA_WD]   = 1'b1;
      else    rnd[FRA_WD-1] = 1'b1;
    end
    t = s + rnd;
    if (sc) return t >>> (FRA_WD + 1);
    return t >>> FRA_WD;
  endfunction

  // The value fits in DO bits only when all bits from DO-1 upward equal the sign bit.
  function automatic logic out_of_range(input logic signed [SW-1:0] v);
    return !((&v[SW-1:DO-1]) || !(|v[SW-1:DO-1]));
  endfunction

  function automatic logic [DO-1:0] fit(input logic signed [SW-1:0] v);
    if ((SAT_EN != 0) && out_of_range(v))
      return v[SW-1] ? {1'b1, {(DO-1){1'b0}}} : {1'b0, {(DO-1){1'b1}}};
    return v[DO-1:0];
  endfunction

  logic en;
  logic val_q;

  assign en    = ~val_q | rdy_i;
  assign rdy_o = en;

  // Stage 1: operands; W.im is conjugated here, one bit wider so -(-2^(WN_WD-1)) fits
  logic                          v1_q, scl1_q;
  logic signed [DATA_INP_WD-1:0] a_re1_q, a_im1_q, b_re1_q, b_im1_q;
  logic signed [WN_WD-1:0]       w_re1_q;
  logic signed [WN_WD:0]         w_im1_q;
  logic signed [WN_WD:0]         w_im_x, w_im_d;

  assign w_im_x = {wn_i[WN_WD-1], wn_i[WN_WD-1:0]};
  assign w_im_d = inv_i ? -w_im_x : w_im_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      scl1_q  <= 1'b0;
      a_re1_q <= '0;
      a_im1_q <= '0;
      b_re1_q <= '0;
      b_im1_q <= '0;
      w_re1_q <= '0;
      w_im1_q <= '0;
    end else if (en) begin
      v1_q    <= val_i;
      scl1_q  <= scl_i;
      a_re1_q <= dat1_i[2*DATA_INP_WD-1:DATA_INP_WD];
      a_im1_q <= dat1_i[DATA_INP_WD-1:0];
      b_re1_q <= dat2_i[2*DATA_INP_WD-1:DATA_INP_WD];
      b_im1_q <= dat2_i[DATA_INP_WD-1:0];
      w_re1_q <= wn_i[2*WN_WD-1:WN_WD];
      w_im1_q <= w_im_d;
    end
  end

  // Stage 2: full-precision complex product B*W
  logic signed [PW-1:0] bre_x, bim_x, wre_x, wim_x, p_re_d, p_im_d;
  logic signed [PW-1:0] p_re_q, p_im_q;
  logic signed [DATA_INP_WD-1:0] a_re2_q, a_im2_q;
  logic                          v2_q, scl2_q;

  assign bre_x  = PW'(b_re1_q);
  assign bim_x  = PW'(b_im1_q);
  assign wre_x  = PW'(w_re1_q);
  assign wim_x  = PW'(w_im1_q);
  assign p_re_d = bre_x * wre_x - bim_x * wim_x;
  assign p_im_d = bre_x * wim_x + bim_x * wre_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      scl2_q  <= 1'b0;
      a_re2_q <= '0;
      a_im2_q <= '0;
      p_re_q  <= '0;
      p_im_q  <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      scl2_q  <= scl1_q;
      a_re2_q <= a_re1_q;
      a_im2_q <= a_im1_q;
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
    end
  end

  // Stage 3: add/subtract, scale, round, range-limit
  logic signed [SW-1:0] a_re_x, a_im_x, p_re_x, p_im_x;
  logic signed [SW-1:0] y1_re, y1_im, y2_re, y2_im;
  logic [2*DO-1:0]      dat1_d, dat2_d;
  logic                 oor_any, ovf_ev;

  assign a_re_x = SW'(a_re2_q) <<< FRA_WD;
  assign a_im_x = SW'(a_im2_q) <<< FRA_WD;
  assign p_re_x = SW'(p_re_q);
  assign p_im_x = SW'(p_im_q);

  assign y1_re = scale(a_re_x + p_re_x, scl2_q);
  assign y1_im = scale(a_im_x + p_im_x, scl2_q);
  assign y2_re = scale(a_re_x - p_re_x, scl2_q);
  assign y2_im = scale(a_im_x - p_im_x, scl2_q);

  assign dat1_d  = {fit(y1_re), fit(y1_im)};
  assign dat2_d  = {fit(y2_re), fit(y2_im)};
  assign oor_any = out_of_range(y1_re) | out_of_range(y1_im) |
                   out_of_range(y2_re) | out_of_range(y2_im);
  assign ovf_ev  = en & v2_q & oor_any;

  logic [2*DO-1:0] dat1_q, dat2_q;
  logic            ovf_pend_q, ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      dat1_q <= '0;
      dat2_q <= '0;
    end else if (en) begin
      val_q  <= v2_q;
      dat1_q <= dat1_d;
      dat2_q <= dat2_d;
    end
  end

  // The event is captured with the result, and the flag rises one edge later.
  // A set on the same edge as a clear takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_pend_q <= ovf_ev;
      ovf_q      <= ovf_pend_q | (ovf_q & ~ovf_clr_i);
    end
  end

  assign val_o  = val_q;
  assign dat1_o = dat1_q;
  assign dat2_o = dat2_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_fft_bfly2_pipe.sv
// Testbench for fft_bfly2_pipe.
// dut0 uses the default configuration: round-half-up with saturation.
// dut1 uses floor rounding with two's-complement wrap.
// Both instances receive identical stimulus.
// Each instance has its own queue of expected results.
module tb_fft_bfly2_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_i, rdy_i, inv_i, scl_i, ovf_clr_i;
  logic [31:0] dat1_i, dat2_i, wn_i;
  logic        rdy_o0, val_o0, ovf_o0, rdy_o1, val_o1, ovf_o1;
  logic [33:0] d1_0, d2_0, d1_1, d2_1;

  always #5 clk = ~clk;

  fft_bfly2_pipe dut0 (
    .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o0),
    .dat1_i(dat1_i), .dat2_i(dat2_i), .wn_i(wn_i), .inv_i(inv_i), .scl_i(scl_i),
    .val_o(val_o0), .rdy_i(rdy_i), .dat1_o(d1_0), .dat2_o(d2_0),
    .ovf_o(ovf_o0), .ovf_clr_i(ovf_clr_i)
  );

  fft_bfly2_pipe #(.RND_MODE(0), .SAT_EN(0)) dut1 (
    .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o1),
    .dat1_i(dat1_i), .dat2_i(dat2_i), .wn_i(wn_i), .inv_i(inv_i), .scl_i(scl_i),
    .val_o(val_o1), .rdy_i(rdy_i), .dat1_o(d1_1), .dat2_o(d2_1),
    .ovf_o(ovf_o1), .ovf_clr_i(ovf_clr_i)
  );

  typedef struct {
    int re1;
    int im1;
    int re2;
    int im2;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(int re1, int im1, int re2, int im2);
    exp_t e;
    e.re1 = re1; e.im1 = im1; e.re2 = re2; e.im2 = im2;
    return e;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic cmp(string name, logic [33:0] d1, logic [33:0] d2, exp_t e);
    logic signed [16:0] r1, i1, r2, i2;
    r1 = d1[33:17]; i1 = d1[16:0];
    r2 = d2[33:17]; i2 = d2[16:0];
    checks++;
    if (int'(r1) != e.re1 || int'(i1) != e.im1 || int'(r2) != e.re2 || int'(i2) != e.im2) begin
      errors++;
      $display("FAIL %s: got X1=(%0d,%0d) X2=(%0d,%0d), expected X1=(%0d,%0d) X2=(%0d,%0d)",
               name, r1, i1, r2, i2, e.re1, e.im1, e.re2, e.im2);
    end
  endtask

  // Scoreboard monitor: compare on every valid cycle, pop only when the beat transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (val_o0) begin
        if (q0.size() == 0) chk("dut0 unexpected beat", 1, 0);
        else begin
          cmp("dut0 result", d1_0, d2_0, q0[0]);
          if (rdy_i) void'(q0.pop_front());
        end
        if (!rdy_i) chk("dut0 rdy_o during stall", int'(rdy_o0), 0);
      end
      if (val_o1) begin
        if (q1.size() == 0) chk("dut1 unexpected beat", 1, 0);
        else begin
          cmp("dut1 result", d1_1, d2_1, q1[0]);
          if (rdy_i) void'(q1.pop_front());
        end
        if (!rdy_i) chk("dut1 rdy_o during stall", int'(rdy_o1), 0);
      end
    end
  end

  task automatic send(int are, int aim, int bre, int bim, int wre, int wim,
                      bit inv, bit scl, exp_t e0, exp_t e1);
    int n;
    n = 0;
    @(negedge clk);
    dat1_i = {16'(are), 16'(aim)};
    dat2_i = {16'(bre), 16'(bim)};
    wn_i   = {16'(wre), 16'(wim)};
    inv_i  = inv;
    scl_i  = scl;
    val_i  = 1'b1;
    while (!rdy_o0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send ready timeout", 1, 0);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1 val_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("drain timeout", 1, 0);
  endtask

  task automatic wait_val(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!val_o0 && n < 20);
    if (!val_o0) chk("val_o wait timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int stale;
    val_i = 0; rdy_i = 1; inv_i = 0; scl_i = 0; ovf_clr_i = 0;
    dat1_i = '0; dat2_i = '0; wn_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset val_o", int'(val_o0), 0);
    chk("reset dat1_o nonzero", int'(d1_0 != 0), 0);
    chk("reset dat2_o nonzero", int'(d2_0 != 0), 0);
    chk("reset ovf_o", int'(ovf_o0), 0);
    chk("reset rdy_o", int'(rdy_o0), 1);

    // basic pass with latency
    send(100, 0, 50, 0, 16384, 0, 0, 0, mk(150, 0, 50, 0), mk(150, 0, 50, 0));
    wait_val(lat);
    chk("latency", lat, 3);
    drain();
    chk("basic ovf_o", int'(ovf_o0), 0);

    // forward then inverse, back-to-back
    send(100, 0, 50, 20, 0, -16384, 0, 0, mk(120, -50, 80, 50), mk(120, -50, 80, 50));
    send(100, 0, 50, 20, 0, -16384, 1, 0, mk(80, 50, 120, -50), mk(80, 50, 120, -50));
    wait_val(lat);
    @(negedge clk);
    chk("back-to-back val_o", int'(val_o0), 1);
    drain();

    // rounding vs floor with scl=1
    send(3, 0, 0, 0, 16384, 0, 0, 1, mk(2, 0, 2, 0), mk(1, 0, 1, 0));
    send(-3, 0, 0, 0, 16384, 0, 0, 1, mk(-1, 0, -1, 0), mk(-2, 0, -2, 0));
    drain();

    // saturation (dut0) and wrap (dut1), sticky overflow
    send(32767, 0, 32767, -32768, 16384, 16384, 0, 0,
         mk(65535, -1, -32768, 1), mk(-32770, -1, -32768, 1));
    wait_val(lat);
    @(negedge clk);
    chk("sat ovf_o dut0", int'(ovf_o0), 1);
    chk("wrap ovf_o dut1", int'(ovf_o1), 1);
    repeat (3) @(negedge clk);
    chk("ovf_o sticky", int'(ovf_o0), 1);
    ovf_clr_i = 1'b1;
    @(negedge clk);
    ovf_clr_i = 1'b0;
    chk("ovf_o cleared dut0", int'(ovf_o0), 0);
    chk("ovf_o cleared dut1", int'(ovf_o1), 0);
    drain();

    // stall: five beats, downstream not ready for three cycles
    fork
      begin
        for (int k = 1; k <= 5; k++)
          send(10*k, -k, k, 2*k, 16384, 0, 0, 0,
               mk(11*k, k, 9*k, -3*k), mk(11*k, k, 9*k, -3*k));
      end
      begin
        repeat (4) @(posedge clk);
        #2 rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rdy_i = 1'b1;
      end
    join
    drain();
    chk("stall queue empty", q0.size(), 0);

    // async reset with beats in flight
    send(32767, 0, 32767, -32768, 16384, 16384, 0, 0,
         mk(65535, -1, -32768, 1), mk(-32770, -1, -32768, 1));
    drain();
    repeat (2) @(negedge clk);
    chk("ovf_o before reset", int'(ovf_o0), 1);
    for (int k = 1; k <= 3; k++)
      send(10*k, -k, k, 2*k, 16384, 0, 0, 0,
           mk(11*k, k, 9*k, -3*k), mk(11*k, k, 9*k, -3*k));
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("async reset val_o dut0", int'(val_o0), 0);
    chk("async reset val_o dut1", int'(val_o1), 0);
    chk("async reset ovf_o dut0", int'(ovf_o0), 0);
    chk("async reset ovf_o dut1", int'(ovf_o1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_o after reset", int'(rdy_o0), 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (val_o0 || val_o1) stale++;
    end
    chk("stale beats after reset", stale, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bfly2_pipe.md
Name: fft_bfly2_pipe

Overview:
- Pipelined, parametrised radix-2 DIT butterfly for the 64-point FFT datapath.
- Computes X1 = A + B·W and X2 = A − B·W per accepted beat, at up to one beat per clock.
- Adds a valid/ready handshake with full-pipeline stall, per-beat inverse (conjugate-twiddle) and ÷2 scaling, selectable floor/round, and optional saturation with a sticky overflow flag.
- Instantiated once per stage by the stage controller.

Parameters:
- DATA_INP_WD, 16: signed width of each real/imag input part.
- DATA_OUT_WD, 17: signed width of each real/imag output part.
- WN_WD, 16: signed width of each twiddle part.
- FRA_WD, 14: twiddle fraction bits; 1.0 = 2^FRA_WD.
- RND_MODE, 1: 0 = floor (arithmetic shift); 1 = round-half-up.
- SAT_EN, 1: 1 = saturate to DATA_OUT_WD; 0 = two's-complement wrap.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- val_i  input  1  input beat valid.
- rdy_o  output  1  block can accept a beat this cycle.
- dat1_i  input  2*DATA_INP_WD  A = {re, im}.
- dat2_i  input  2*DATA_INP_WD  B = {re, im}.
- wn_i  input  2*WN_WD  W = {re, im}.
- inv_i  input  1  per beat: 1 = use conj(W) (IFFT).
- scl_i  input  1  per beat: 1 = extra right shift by 1 (block scaling).
- val_o  output  1  output beat valid.
- rdy_i  input  1  downstream ready.
- dat1_o  output  2*DATA_OUT_WD  X1 = {re, im}.
- dat2_o  output  2*DATA_OUT_WD  X2 = {re, im}.
- ovf_o  output  1  sticky overflow; set on any saturation/wrap event.
- ovf_clr_i  input  1  synchronous clear of ovf_o.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: val_o=0, dat1_o=0, dat2_o=0, ovf_o=0. All internal stage valids clear.
  - Reset mid-operation discards every in-flight beat.
  - rdy_o is 1 immediately after reset release.
- Advance enable: en = ~val_o | rdy_i. rdy_o = en (combinational).
  - Beat accepted when val_i & rdy_o.
  - When en=0, all pipeline registers and valids hold; dat1_o/dat2_o are stable while val_o & ~rdy_i.
- Pipeline: 3 stages. An accepted beat appears at val_o exactly 3 cycles after acceptance when never stalled; each stall cycle adds 1.
  - Bubbles (val_i=0) propagate as valid=0; their data is don't-care, but registers may hold.
- S1: register A, B, inv, scl. Register W with im negated when inv=1.
  - Negating −2^(WN_WD−1) uses WN_WD+1 bits. No wrap.
- S2: full-precision complex products:
  - Pre = Bre·Wre − Bim·Wim
  - Pim = Bre·Wim + Bim·Wre
  - Each is DATA_INP_WD+WN_WD+2 bits, registered.
- S3:
  - Sum = (A<<FRA_WD) ± P, with one guard bit.
  - Shift right by SH = FRA_WD+scl.
  - RND_MODE=1: add 2^(SH−1) before the arithmetic shift, so ties round toward +inf.
  - Clamp to [−2^(DATA_OUT_WD−1), 2^(DATA_OUT_WD−1)−1] when SAT_EN=1; otherwise truncate.
  - Register the result to the outputs.
- Overflow: the ovf event fires if any of the 4 results leaves the output range, checked on a valid beat only while it is loaded into the output register.
  - ovf_o is set on the next edge and held until ovf_clr_i.
  - Set and clear in the same cycle: set wins.
- Twiddle range: callers keep |W| ≤ 2^FRA_WD. Values outside that range are computed anyway, with no special handling.

Test Plan:
- Basic pass, ratio 1: A=(100,0), B=(50,0), W=(16384,0), inv=0, scl=0 -> 3 cycles later val_o=1, X1=(150,0), X2=(50,0), ovf_o=0.
- Forward vs inverse: A=(100,0), B=(50,20), W=(0,−16384).
  - inv=0 -> X1=(120,−50), X2=(80,50).
  - Next beat with inv=1 -> X1=(80,50), X2=(120,−50).
  - Issued back-to-back, the outputs appear on consecutive cycles.
- Rounding, scl=1, B=0:
  - A=(3,0): RND_MODE=1 -> X1.re=2; RND_MODE=0 -> 1.
  - A=(−3,0): RND_MODE=1 -> −1; RND_MODE=0 -> −2.
- Saturation: A=(32767,0), B=(32767,−32768), W=(16384,16384), scl=0 -> X1.re=65535 clamped, ovf_o=1 the cycle after val_o.
  - ovf_o stays 1 until a ovf_clr_i pulse, then 0.
  - With SAT_EN=0, X1.re wraps to −32770 (98302 − 131072).
- Stall: 5 consecutive beats with rdy_i held 0 from cycle 4 for 3 cycles.
  - Required: rdy_o=0 during the stall, outputs frozen, no beat lost or duplicated.
  - All 5 results emerge in order.
- Async reset: assert rst for 1 cycle while 3 beats are in flight -> val_o=0 and ovf_o=0 immediately, no stale beat emerges afterwards, rdy_o=1 after release.
